// File: rtl/lsm_sequencer_if.sv
// lsm_sequencer_if
//   Bundles the decode-side request, the memory beat channel and the base
//   writeback strobe of the load/store-multiple sequencer.
//   Ports (by modport):
//     master (sequencer): in  start, is_load, increment, writeback, base_reg,
//                             reglist, base_addr, mem_ready
//                         out busy, xfer_valid, mem_addr, mem_we, mem_re,
//                             xfer_reg, wb_valid, wb_reg, wb_data, done
//     slave  (pipeline/memory side): the mirror image of master.
interface lsm_sequencer_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  start;
  logic                  is_load;
  logic                  increment;
  logic                  writeback;
  logic [3:0]            base_reg;
  logic [15:0]           reglist;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic                  mem_ready;

  logic                  busy;
  logic                  xfer_valid;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic                  mem_re;
  logic [3:0]            xfer_reg;
  logic                  wb_valid;
  logic [3:0]            wb_reg;
  logic [ADDR_WIDTH-1:0] wb_data;
  logic                  done;

  modport master (
    input  start, is_load, increment, writeback, base_reg, reglist, base_addr, mem_ready,
    output busy, xfer_valid, mem_addr, mem_we, mem_re, xfer_reg, wb_valid, wb_reg, wb_data, done
  );

  modport slave (
    output start, is_load, increment, writeback, base_reg, reglist, base_addr, mem_ready,
    input  busy, xfer_valid, mem_addr, mem_we, mem_re, xfer_reg, wb_valid, wb_reg, wb_data, done
  );
endinterface

// File: rtl/lsm_sequencer.sv
// lsm_sequencer
//   Sequences an LDM/STM instruction into one memory beat per listed
//   register (lowest register first, ascending addresses), then optionally
//   writes the updated base register back and pulses done.
//   Ports:
//     clk    : single clock, rising edge
//     reset  : synchronous, active-low
//     bus    : lsm_sequencer_if.master (request, beat channel, writeback, done)
//   Parameters:
//     ADDR_WIDTH : width of base, beat address and writeback data
//     WORD_BYTES : address step per transferred register
module lsm_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_BYTES = 4
) (
  input logic             clk,
  input logic             reset,
  lsm_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, XFER, WB, FIN} stateT;

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(WORD_BYTES);

  stateT                 state;
  logic [15:0]           pending;
  logic [15:0]           nextPending;
  logic                  wbEffQ;
  logic [3:0]            baseRegQ;
  logic [ADDR_WIDTH-1:0] wbNewQ;
  logic [4:0]            startCount;
  logic [ADDR_WIDTH-1:0] startSpan;

  logic                  xferValidQ;
  logic [ADDR_WIDTH-1:0] memAddrQ;
  logic                  memWeQ;
  logic                  memReQ;
  logic [3:0]            xferRegQ;
  logic                  wbValidQ;
  logic [3:0]            wbRegQ;
  logic [ADDR_WIDTH-1:0] wbDataQ;
  logic                  doneQ;

  function automatic logic [4:0] popCount(input logic [15:0] v);
    popCount = 5'd0;
    for (int i = 0; i < 16; i++) popCount = popCount + 5'(v[i]);
  endfunction

  // Scanning downward lets the lowest set bit overwrite any higher one.
  function automatic logic [3:0] lowestSet(input logic [15:0] v);
    lowestSet = 4'd0;
    for (int i = 15; i >= 0; i--) if (v[i]) lowestSet = 4'(i);
  endfunction

  // Request-side arithmetic: total span of the transfer and the pending
  // list with the beat currently on the bus removed.
  always_comb begin
    startCount  = popCount(bus.reglist);
    startSpan   = ADDR_WIDTH'(WORD_BYTES * int'(startCount));
    nextPending = pending & ~(16'd1 << xferRegQ);
  end

  // Sequencer FSM. The final base value and whether writeback happens are
  // decided at start, so WB only has to present them. A base register that
  // is itself loaded suppresses the writeback (the loaded value wins).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      pending    <= 16'd0;
      wbEffQ     <= 1'b0;
      baseRegQ   <= 4'd0;
      wbNewQ     <= '0;
      xferValidQ <= 1'b0;
      memAddrQ   <= '0;
      memWeQ     <= 1'b0;
      memReQ     <= 1'b0;
      xferRegQ   <= 4'd0;
      wbValidQ   <= 1'b0;
      wbRegQ     <= 4'd0;
      wbDataQ    <= '0;
      doneQ      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            baseRegQ <= bus.base_reg;
            wbEffQ   <= bus.writeback & ~(bus.is_load & bus.reglist[bus.base_reg]);
            wbNewQ   <= bus.increment ? bus.base_addr + startSpan
                                      : bus.base_addr - startSpan;
            pending  <= bus.reglist;
            if (startCount != 5'd0) begin
              state      <= XFER;
              xferValidQ <= 1'b1;
              memWeQ     <= ~bus.is_load;
              memReQ     <= bus.is_load;
              memAddrQ   <= bus.increment ? bus.base_addr : bus.base_addr - startSpan;
              xferRegQ   <= lowestSet(bus.reglist);
            end else begin
              state <= FIN;
              doneQ <= 1'b1;
            end
          end
        end
        XFER: begin
          if (bus.mem_ready) begin
            pending <= nextPending;
            if (nextPending != 16'd0) begin
              memAddrQ <= memAddrQ + STEP;
              xferRegQ <= lowestSet(nextPending);
            end else begin
              xferValidQ <= 1'b0;
              memWeQ     <= 1'b0;
              memReQ     <= 1'b0;
              memAddrQ   <= '0;
              xferRegQ   <= 4'd0;
              if (wbEffQ) begin
                state    <= WB;
                wbValidQ <= 1'b1;
                wbRegQ   <= baseRegQ;
                wbDataQ  <= wbNewQ;
              end else begin
                state <= FIN;
                doneQ <= 1'b1;
              end
            end
          end
        end
        WB: begin
          state    <= FIN;
          wbValidQ <= 1'b0;
          wbRegQ   <= 4'd0;
          wbDataQ  <= '0;
          doneQ    <= 1'b1;
        end
        FIN: begin
          state <= IDLE;
          doneQ <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output drive: busy follows the state directly, everything else is a
  // registered copy.
  assign bus.busy       = (state != IDLE);
  assign bus.xfer_valid = xferValidQ;
  assign bus.mem_addr   = memAddrQ;
  assign bus.mem_we     = memWeQ;
  assign bus.mem_re     = memReQ;
  assign bus.xfer_reg   = xferRegQ;
  assign bus.wb_valid   = wbValidQ;
  assign bus.wb_reg     = wbRegQ;
  assign bus.wb_data    = wbDataQ;
  assign bus.done       = doneQ;

endmodule

// File: doc/lsm_sequencer.md
LSM_SEQUENCER -- requirements
Module: lsm_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of base, address and writeback data.
REQ-002 Parameter WORD_BYTES, default 4: address step per transferred register.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block.
REQ-005 start  in  1  decode-stage request to begin an LDM/STM; sampled only in IDLE.
REQ-006 is_load  in  1  1 = load multiple, 0 = store multiple.
REQ-007 increment  in  1  1 = increment-after (IA), 0 = decrement-before (DB).
REQ-008 writeback  in  1  1 = update base register at end.
REQ-009 base_reg  in  4  base register number Rn.
REQ-010 reglist  in  16  register list, bit i = register i.
REQ-011 base_addr  in  ADDR_WIDTH  current value of Rn.
REQ-012 mem_ready  in  1  memory accepts the current beat this cycle.
REQ-013 busy  out  1  sequence in progress; pipeline stalls fetch/decode while high.
REQ-014 xfer_valid  out  1  a transfer beat is presented.
REQ-015 mem_addr  out  ADDR_WIDTH  beat address.
REQ-016 mem_we / mem_re  out  1 each  store / load beat qualifiers (= xfer_valid & ~is_load / & is_load).
REQ-017 xfer_reg  out  4  register number for the current beat.
REQ-018 wb_valid  out  1  one-cycle base writeback strobe.
REQ-019 wb_reg  out  4  = latched base_reg.
REQ-020 wb_data  out  ADDR_WIDTH  new base value.
REQ-021 done  out  1  one-cycle completion pulse.

Function
REQ-022 States SHALL be IDLE, XFER, WB, FIN; encoding free.
REQ-023 In IDLE with start=1, the block SHALL latch is_load, increment, writeback, base_reg, reglist, base_addr, and N=popcount(reglist) (0..16); go to XFER if N>0, else FIN.
REQ-024 start SHALL be ignored in every state other than IDLE.
REQ-025 busy SHALL be 1 in XFER, WB, FIN; 0 in IDLE (combinational from state, no start-cycle look-ahead).
REQ-026 First beat address: IA = base_addr; DB = base_addr - WORD_BYTES*N (modulo 2^ADDR_WIDTH).
REQ-027 Beats SHALL issue in ascending register order, lowest set pending bit first, addresses ascending by WORD_BYTES.
REQ-028 In XFER, xfer_valid=1; mem_addr, xfer_reg, mem_we, mem_re SHALL hold stable until mem_ready=1.
REQ-029 On mem_ready=1 in XFER: clear that pending bit, advance address by WORD_BYTES; if it was the last bit, go to WB if writeback is effective, else FIN.
REQ-030 A beat accepted each cycle SHALL give N consecutive transfer cycles (no bubbles).
REQ-031 Effective writeback = writeback & ~(is_load & reglist[base_reg]); loaded base wins.
REQ-032 WB: wb_valid=1 for one cycle, wb_data = IA: base+WORD_BYTES*N, DB: base-WORD_BYTES*N; then FIN.
REQ-033 N=0: no beats, no writeback regardless of writeback input.
REQ-034 FIN: done=1 for one cycle, then IDLE; a start in the following IDLE cycle SHALL be accepted.
REQ-035 Total latency from start edge to done = N + (1 if effective writeback) + 1 cycles with mem_ready held high.
REQ-036 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH, no error flag.

Reset
REQ-037 reset==0 at any edge, including mid-XFER or WB, SHALL force IDLE and clear pending list; an in-flight beat is abandoned.
REQ-038 In reset and IDLE all outputs SHALL be 0 (busy, xfer_valid, mem_we, mem_re, wb_valid, done, mem_addr, xfer_reg, wb_reg, wb_data).
REQ-039 start asserted with reset==0 SHALL be ignored.

Verification
REQ-040 STM IA, reglist=0x000E, base=0x1000, writeback=1, base_reg=13, mem_ready=1 -> beats (r1,0x1000),(r2,0x1004),(r3,0x1008), mem_we=1; wb r13=0x100C; done 5 cycles after start.
REQ-041 LDM DB, reglist=0x8001, base=0x2000, writeback=1 -> beats (r0,0x1FF8),(r15,0x1FFC), mem_re=1; wb_data=0x1FF8.
REQ-042 LDM IA, base_reg=2, reglist=0x0006, writeback=1 -> 2 beats, wb_valid never asserted, done 3 cycles after start.
REQ-043 reglist=0 with writeback=1 -> no xfer_valid, no wb_valid, done 1 cycle after start.
REQ-044 mem_ready low 3 cycles on beat 2 -> mem_addr/xfer_reg stable, second start during busy ignored, sequence resumes unchanged.
REQ-045 reset=0 mid-XFER of 8-register STM -> next cycle all outputs 0, IDLE; fresh start then runs full sequence from its own base.
